// File: rtl/cheetah_pkg.sv
// cheetah_pkg -- shared definitions for the cheetah core pipeline.
//   XLEN      : default datapath width in bits.
//   alu_op_t  : 5-bit ALU opcode encodings (ADD .. LUI). Codes above LUI are
//               legal on the wire and are carried through the pipeline as-is.
//   fwd_sel_t : operand forwarding source (register file, MEM stage, WB stage).
package cheetah_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SLL  = 5'b00101,
    ALU_SRL  = 5'b00110,
    ALU_SRA  = 5'b00111,
    ALU_SLT  = 5'b01000,
    ALU_SLTU = 5'b01001,
    ALU_LUI  = 5'b01010
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_mux.sv
// forward_mux -- single-operand forwarding select.
// Optional feature macro: FORWARDING_EN. When undefined, the operand is
// always the register-file value and the M/W inputs are ignored.
// Ports:
//   rs_i            source register index of the E-stage instruction
//   reg_val_i       register-file value read in decode
//   alu_result_m_i, rd_m_i, reg_write_m_i : MEM-stage result source
//   result_w_i,     rd_w_i, reg_write_w_i : WB-stage result source
//   fwd_o           selected operand (combinational)
module forward_mux #(
  parameter int XLEN = cheetah_pkg::XLEN
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] reg_val_i,
  input  logic [XLEN-1:0] alu_result_m_i,
  input  logic [4:0]      rd_m_i,
  input  logic            reg_write_m_i,
  input  logic [XLEN-1:0] result_w_i,
  input  logic [4:0]      rd_w_i,
  input  logic            reg_write_w_i,
  output logic [XLEN-1:0] fwd_o
);
  import cheetah_pkg::*;

  fwd_sel_t sel_s;

`ifdef FORWARDING_EN
  // Pick the youngest producer; x0 is never forwarded since it reads as zero.
  always_comb begin
    sel_s = FWD_REG;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
      sel_s = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_REG;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{rs_i, alu_result_m_i, rd_m_i, reg_write_m_i,
                          result_w_i, rd_w_i, reg_write_w_i};

  // Without forwarding the register-file value is always used.
  always_comb begin
    sel_s = FWD_REG;
  end
`endif

  // Operand mux driven by the selected source.
  always_comb begin
    fwd_o = reg_val_i;
    case (sel_s)
      FWD_MEM: fwd_o = alu_result_m_i;
      FWD_WB:  fwd_o = result_w_i;
      FWD_REG: fwd_o = reg_val_i;
      default: fwd_o = reg_val_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding and ALU
// source selection.
// Optional feature macro: FORWARDING_EN (enables MEM/WB result forwarding).
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   StallE, FlushE          hold the E register / load a bubble (flush wins)
//   RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD, alu_opD,
//   ALUSrcAD, ALUSrcBD, RegWriteD, ValidD   decode-side fields
//   ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW  forwarding sources
//   SrcA, SrcB, WriteDataE  ALU operands and store data (combinational from
//                           the E registers so a stalled instruction sees
//                           fresh M/W results)
//   PCE, alu_opE, RdE, RegWriteE, ValidE   registered E fields
module id_ex_stage #(
  parameter int XLEN = cheetah_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [4:0]      alu_opD,
  input  logic            ALUSrcAD,
  input  logic            ALUSrcBD,
  input  logic            RegWriteD,
  input  logic            ValidD,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdM,
  input  logic [4:0]      RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCE,
  output logic [4:0]      alu_opE,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            ValidE
);
  import cheetah_pkg::*;

  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, alu_op_q, alu_op_d;
  logic            srca_q, srca_d, srcb_q, srcb_d;
  logic            regwrite_q, regwrite_d, valid_q, valid_d;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s;

  // Next-state: bubble on flush, capture when not stalled, otherwise hold.
  always_comb begin
    rd1_d = rd1_q;  rd2_d = rd2_q;  pc_d = pc_q;  imm_d = imm_q;
    rs1_d = rs1_q;  rs2_d = rs2_q;  rd_d = rd_q;  alu_op_d = alu_op_q;
    srca_d = srca_q;  srcb_d = srcb_q;
    regwrite_d = regwrite_q;  valid_d = valid_q;
    if (FlushE) begin
      rd1_d = '0;  rd2_d = '0;  pc_d = '0;  imm_d = '0;
      rs1_d = 5'd0;  rs2_d = 5'd0;  rd_d = 5'd0;  alu_op_d = ALU_ADD;
      srca_d = 1'b0;  srcb_d = 1'b0;
      regwrite_d = 1'b0;  valid_d = 1'b0;
    end else if (!StallE) begin
      rd1_d = RD1D;  rd2_d = RD2D;  pc_d = PCD;  imm_d = ImmExtD;
      rs1_d = Rs1D;  rs2_d = Rs2D;  rd_d = RdD;  alu_op_d = alu_opD;
      srca_d = ALUSrcAD;  srcb_d = ALUSrcBD;
      // An invalid slot must never write the register file.
      regwrite_d = RegWriteD & ValidD;
      valid_d = ValidD;
    end else begin
      valid_d = valid_q;
    end
  end

  // E register bank; reset loads the same bubble as a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_q <= '0;  rd2_q <= '0;  pc_q <= '0;  imm_q <= '0;
      rs1_q <= 5'd0;  rs2_q <= 5'd0;  rd_q <= 5'd0;  alu_op_q <= ALU_ADD;
      srca_q <= 1'b0;  srcb_q <= 1'b0;
      regwrite_q <= 1'b0;  valid_q <= 1'b0;
    end else begin
      rd1_q <= rd1_d;  rd2_q <= rd2_d;  pc_q <= pc_d;  imm_q <= imm_d;
      rs1_q <= rs1_d;  rs2_q <= rs2_d;  rd_q <= rd_d;  alu_op_q <= alu_op_d;
      srca_q <= srca_d;  srcb_q <= srcb_d;
      regwrite_q <= regwrite_d;  valid_q <= valid_d;
    end
  end

  forward_mux #(.XLEN(XLEN)) u_fwd_a (
    .rs_i(rs1_q), .reg_val_i(rd1_q),
    .alu_result_m_i(ALUResultM), .rd_m_i(RdM), .reg_write_m_i(RegWriteM),
    .result_w_i(ResultW), .rd_w_i(RdW), .reg_write_w_i(RegWriteW),
    .fwd_o(fwd_a_s)
  );

  forward_mux #(.XLEN(XLEN)) u_fwd_b (
    .rs_i(rs2_q), .reg_val_i(rd2_q),
    .alu_result_m_i(ALUResultM), .rd_m_i(RdM), .reg_write_m_i(RegWriteM),
    .result_w_i(ResultW), .rd_w_i(RdW), .reg_write_w_i(RegWriteW),
    .fwd_o(fwd_b_s)
  );

  assign SrcA       = srca_q ? pc_q : fwd_a_s;
  assign SrcB       = srcb_q ? imm_q : fwd_b_s;
  assign WriteDataE = fwd_b_s;
  assign PCE        = pc_q;
  assign alu_opE    = alu_op_q;
  assign RdE        = rd_q;
  assign RegWriteE  = regwrite_q;
  assign ValidE     = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed plus randomized self-checking bench for
// id_ex_stage against a behavioural model of the E-stage contents.
// Honours FORWARDING_EN the same way as the design build.
module tb_id_ex_stage;

  localparam int XLEN = 32;

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, ALUResultM, ResultW;
  logic [4:0] Rs1D, Rs2D, RdD, alu_opD, RdM, RdW;
  logic ALUSrcAD, ALUSrcBD, RegWriteD, ValidD, RegWriteM, RegWriteW;
  logic [XLEN-1:0] SrcA, SrcB, WriteDataE, PCE;
  logic [4:0] alu_opE, RdE;
  logic RegWriteE, ValidE;

  int vectors = 0;
  int miscompares = 0;

  // Model of the instruction currently held in E.
  logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_imm;
  logic [4:0] m_rs1, m_rs2, m_rd, m_op;
  logic m_asel, m_bsel, m_rw, m_v;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .alu_opD(alu_opD),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD), .ValidD(ValidD),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .SrcA(SrcA), .SrcB(SrcB), .WriteDataE(WriteDataE), .PCE(PCE),
    .alu_opE(alu_opE), .RdE(RdE), .RegWriteE(RegWriteE), .ValidE(ValidE)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value the instruction in E should see for a source register.
  function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (FWD_EN && RegWriteM && RdM != 5'd0 && RdM == rs) return ALUResultM;
    if (FWD_EN && RegWriteW && RdW != 5'd0 && RdW == rs) return ResultW;
    return rf;
  endfunction

  task automatic model_clear();
    m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_imm = '0;
    m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_op = 5'd0;
    m_asel = 1'b0; m_bsel = 1'b0; m_rw = 1'b0; m_v = 1'b0;
  endtask

  // One rising edge, model update from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || FlushE) model_clear();
    else if (!StallE) begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_imm = ImmExtD;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD; m_op = alu_opD;
      m_asel = ALUSrcAD; m_bsel = ALUSrcBD;
      m_v = ValidD; m_rw = RegWriteD && ValidD;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [XLEN-1:0] fb;
    fb = operand(m_rs2, m_rd2);
    check({tag, ".SrcA"}, SrcA, m_asel ? m_pc : operand(m_rs1, m_rd1));
    check({tag, ".SrcB"}, SrcB, m_bsel ? m_imm : fb);
    check({tag, ".WD"}, WriteDataE, fb);
    check({tag, ".PCE"}, PCE, m_pc);
    check({tag, ".op"}, {27'd0, alu_opE}, {27'd0, m_op});
    check({tag, ".RdE"}, {27'd0, RdE}, {27'd0, m_rd});
    check({tag, ".RegWr"}, {31'd0, RegWriteE}, {31'd0, m_rw});
    check({tag, ".Valid"}, {31'd0, ValidE}, {31'd0, m_v});
  endtask

  task automatic quiet_mw();
    ALUResultM = '0; ResultW = '0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic rand_d();
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    RdD = 5'($urandom); alu_opD = 5'($urandom);
    ALUSrcAD = 1'($urandom); ALUSrcBD = 1'($urandom);
    RegWriteD = 1'($urandom); ValidD = 1'($urandom);
  endtask

  task automatic rand_mw();
    ALUResultM = $urandom; ResultW = $urandom;
    RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    rand_d(); ValidD = 1'b1; RegWriteD = 1'b1;
    quiet_mw();

    // Reset with a valid instruction presented.
    tick(); tick();
    check("rst.SrcA", SrcA, 32'd0);
    check("rst.SrcB", SrcB, 32'd0);
    check("rst.WD", WriteDataE, 32'd0);
    check("rst.PCE", PCE, 32'd0);
    check("rst.Valid", {31'd0, ValidE}, 32'd0);
    check("rst.RegWr", {31'd0, RegWriteE}, 32'd0);
    check_all("rst");

    // Plain pass-through.
    rst_n = 1'b1;
    RD1D = 32'd5; RD2D = 32'd7; alu_opD = 5'b00001; Rs1D = 5'd1; Rs2D = 5'd2;
    ALUSrcAD = 1'b0; ALUSrcBD = 1'b0; ValidD = 1'b1; RegWriteD = 1'b1;
    tick();
    check("pass.SrcA", SrcA, 32'd5);
    check("pass.SrcB", SrcB, 32'd7);
    check("pass.op", {27'd0, alu_opE}, 32'd1);
    check_all("pass");

    // M over W priority, then W alone.
    Rs1D = 5'd3; RD1D = 32'h1234;
    tick();
    RdM = 5'd3; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
    ALUResultM = 32'hAA; ResultW = 32'hBB;
    #1;
    check("prio.M", SrcA, FWD_EN ? 32'hAA : 32'h1234);
    RdM = 5'd0;
    #1;
    check("prio.W", SrcA, FWD_EN ? 32'hBB : 32'h1234);
    quiet_mw();

    // x0 is never forwarded.
    Rs2D = 5'd0; RD2D = 32'd0;
    tick();
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hFF;
    #1;
    check("x0.SrcB", SrcB, 32'd0);
    check("x0.WD", WriteDataE, 32'd0);
    quiet_mw();

    // Stall holds, flush beats stall.
    PCD = 32'h100; ValidD = 1'b1;
    tick();
    check("stall.cap", PCE, 32'h100);
    StallE = 1'b1; PCD = 32'h200; RD1D = 32'h55;
    tick();
    check("stall.hold", PCE, 32'h100);
    check_all("stall");
    FlushE = 1'b1;
    tick();
    check("flush.Valid", {31'd0, ValidE}, 32'd0);
    check("flush.PCE", PCE, 32'd0);
    StallE = 1'b0; FlushE = 1'b0;

    // PC / immediate select.
    ALUSrcAD = 1'b1; ALUSrcBD = 1'b1; PCD = 32'h40; ImmExtD = 32'h1000;
    tick();
    check("sel.SrcA", SrcA, 32'h40);
    check("sel.SrcB", SrcB, 32'h1000);

    // Random traffic; M/W change every cycle, including while stalled.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      rand_mw();
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      rst_n  = ($urandom_range(0, 39) != 0);
      tick();
      check_all("rnd");
      rand_mw();
      #1;
      check_all("rnd.mw");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports StallE, FlushE  input  1 each  hold the E register / insert a bubble.
REQ-005 The block SHALL have ports RD1D, RD2D, PCD, ImmExtD  input  XLEN each  decode operands, PC and immediate.
REQ-006 The block SHALL have ports Rs1D, Rs2D, RdD  input  5 each  register indices.
REQ-007 The block SHALL have ports alu_opD  input  5 (ALU opcode); ALUSrcAD, ALUSrcBD, RegWriteD, ValidD  input  1 each  (A: select PC; B: select immediate).
REQ-008 The block SHALL have ports ALUResultM, ResultW  input  XLEN each; RdM, RdW  input  5 each; RegWriteM, RegWriteW  input  1 each  forwarding sources.
REQ-009 The block SHALL have ports SrcA, SrcB, WriteDataE, PCE  output  XLEN each  ALU operands, store data, PC.
REQ-010 The block SHALL have ports alu_opE  output  5; RdE  output  5; RegWriteE, ValidE  output  1 each.

Function
REQ-011 On a rising edge with FlushE=0 and StallE=0, all D-side inputs SHALL be captured into E registers; latency D to E is one cycle.
REQ-012 With StallE=1 and FlushE=0, all E registers SHALL hold their value.
REQ-013 With FlushE=1, the registers SHALL load a bubble regardless of StallE: ValidE=0, RegWriteE=0, alu_opE=5'b00000, RdE=0, all other registers 0.
REQ-014 alu_opD SHALL pass through unchanged, including codes above 5'b01010.
REQ-015 fwdA SHALL be ALUResultM if RegWriteM, RdM!=0 and RdM==Rs1E; else ResultW if RegWriteW, RdW!=0 and RdW==Rs1E; else RD1E. M has priority over W.
REQ-016 fwdB SHALL use the same rule with Rs2E and RD2E.
REQ-017 The outputs SHALL be SrcA = ALUSrcAE ? PCE : fwdA, SrcB = ALUSrcBE ? ImmExtE : fwdB, and WriteDataE = fwdB.
REQ-018 Forwarding SHALL be combinational from the registered E fields, so a held (stalled) instruction picks up newly arriving M/W results.
REQ-019 When ValidE=0, RegWriteE SHALL be 0.

Reset
REQ-020 When rst_n=0 at a rising edge, the registers SHALL load the bubble of REQ-013; rst_n overrides FlushE and StallE.
REQ-021 After reset, SrcA SHALL be 0, SrcB 0, WriteDataE 0, PCE 0, alu_opE 0, RdE 0, RegWriteE 0 and ValidE 0, until the first capture.

Configuration
REQ-022 With macro FORWARDING_EN defined, REQ-015 and REQ-016 SHALL apply.
REQ-023 Without FORWARDING_EN, fwdA SHALL equal RD1E and fwdB SHALL equal RD2E; the M/W ports SHALL remain present but unused.

Structure
REQ-024 Package cheetah_pkg SHALL hold the alu_op_t 5-bit encodings (ADD 00000 through LUI 01010), the fwd_sel_t enum (REG, MEM, WB) and XLEN.
REQ-025 One sub-module, forward_mux, SHALL implement a single-operand forwarding select; it SHALL be instantiated twice.

Verification
REQ-026 Reset: rst_n=0 for 2 cycles with ValidD=1 -> ValidE=0, RegWriteE=0 and all outputs 0.
REQ-027 Pass-through: RD1D=5, RD2D=7, alu_opD=00001, ALUSrcBD=0, no hazards, one edge -> SrcA=5, SrcB=7, alu_opE=00001.
REQ-028 Priority: Rs1E=3, RdM=3, RdW=3, both RegWrite=1, ALUResultM=0xAA, ResultW=0xBB -> SrcA=0xAA; with RdM=0 instead -> SrcA=0xBB.
REQ-029 x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0 -> SrcB=0 and WriteDataE=0.
REQ-030 Stall then flush: capture PCD=0x100, then StallE=1 with new D inputs -> PCE stays 0x100; then FlushE=1 and StallE=1 -> ValidE=0 and PCE=0.
REQ-031 Immediate and PC select: ALUSrcAD=1, ALUSrcBD=1, PCD=0x40, ImmExtD=0x1000 -> SrcA=0x40, SrcB=0x1000; build without FORWARDING_EN plus REQ-028 stimulus -> SrcA=RD1E.
